cached_memory: RTL and testbench
================================

CACHED_MEMORY -- requirements
Module: cached_memory

Interface
REQ-001 Parameter: WORD_LENGTH, 32, data word width in bits.
REQ-002 Parameter: CNT_WIDTH, 16, width of the statistics counters.
REQ-003 Port: clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 Port: rst_n  input  1  reset, synchronous and active-low.
REQ-005 Port: address  input  15  word address of the current read access; one access per cycle.
REQ-006 Port: hit  output  1  high when the current address hits in the cache (combinational).
REQ-007 Port: mem_out  output  WORD_LENGTH  data word at the current address (combinational).
REQ-008 Port: access_count  output  CNT_WIDTH  number of accesses since reset.
REQ-009 Port: hit_count  output  CNT_WIDTH  number of hits since reset.

Function
REQ-010 Main memory SHALL be read-only, with 32768 words (15-bit word address) and 4-word blocks.
REQ-011 Main memory word at address A SHALL equal A zero-extended to WORD_LENGTH; no file initialisation.
REQ-012 Cache SHALL be direct-mapped: 256 lines, each holding 4 words, one 5-bit tag and one valid bit.
REQ-013 Address split SHALL be: offset = address[1:0], index = address[9:2], tag = address[14:10].
REQ-014 hit SHALL be 1 exactly when line[index] is valid and its stored tag equals the address tag; evaluation is combinational with zero latency.
REQ-015 On hit, mem_out SHALL be the cached word at the offset.
REQ-016 On miss, mem_out SHALL be the main-memory word at the offset of the addressed block, in the same cycle.
REQ-017 On miss, the controller SHALL assert an internal cache_write, the four block words SHALL be presented to the cache, and at the next rising edge the cache SHALL store all 4 words, set the tag and set the valid bit.
REQ-018 Refill SHALL overwrite any previous line contents at that index without writeback, since the memory is read-only.
REQ-019 The hit output SHALL reflect the lookup before the refill; a repeated address in the next cycle SHALL hit.
REQ-020 Each rising edge with rst_n=1 SHALL count one access: access_count increments; hit_count increments if hit=1.
REQ-021 Both counters SHALL saturate at all-ones and never wrap.
REQ-022 Address changes mid-cycle SHALL only affect the combinational outputs; the refill uses the address sampled at the edge.

Reset
REQ-023 At a rising edge with rst_n=0, all 256 valid bits SHALL clear and both counters SHALL become 0.
REQ-024 Tags and data SHALL be left unreset.
REQ-025 No refill or count SHALL occur in a reset cycle, so the first access after reset always misses.
REQ-026 Reset asserted mid-sequence SHALL take precedence over a pending refill in the same cycle.

Structure
REQ-027 WORD_LENGTH and the address-field widths (offset 2, index 8, tag 5) SHALL reside in a shared constants package/header.
REQ-028 cached_memory SHALL instantiate three sub-modules:
- cache_memory: tag/valid/data arrays, clocked refill, combinational hit and read.
- main_memory: combinational 4-word block read.
- memory_controller: combinational hit/miss data selection and cache_write generation.
REQ-029 Counters SHALL reside in cached_memory.

Verification
REQ-030 Reset, then address 0x0005 for one cycle -> hit=0, mem_out=0x00000005; next cycle same address -> hit=1, mem_out=0x00000005.
REQ-031 After refill of 0x0004, addresses 0x0006 and 0x0007 -> hit=1, mem_out 0x00000006 and 0x00000007.
REQ-032 Conflict test, same index with different tag:
- access 0x0010, then 0x0410 -> 0x0410 misses with mem_out=0x00000410.
- then 0x0010 -> miss again.
REQ-033 Sequential sweep 0x0000..0x03FF after reset -> exactly 1 miss per 4 accesses; access_count=1024, hit_count=768.
REQ-034 Mid-sweep rst_n=0 for one cycle -> counters read 0; previously cached address misses.
REQ-035 Force access_count near all-ones, then continue accessing -> counter holds at 0xFFFF.

Source files
------------

// File: rtl/cached_memory_pkg.sv
// Shared constants and address-field helpers for the direct-mapped cached memory.
// The word address is split into tag | index | offset, most significant first.
package cached_memory_pkg;

  localparam int WORD_LENGTH  = 32;
  localparam int ADDR_WIDTH   = 15;
  localparam int OFFSET_WIDTH = 2;
  localparam int INDEX_WIDTH  = 8;
  localparam int TAG_WIDTH    = 5;
  localparam int BLOCK_WORDS  = 1 << OFFSET_WIDTH;
  localparam int LINE_COUNT   = 1 << INDEX_WIDTH;

  typedef struct packed {
    logic [TAG_WIDTH-1:0]    tag;
    logic [INDEX_WIDTH-1:0]  index;
    logic [OFFSET_WIDTH-1:0] offset;
  } addr_fields_t;

  function automatic addr_fields_t split_address(input logic [ADDR_WIDTH-1:0] address);
    return addr_fields_t'(address);
  endfunction

endpackage

// File: rtl/cache_memory.sv
// Direct-mapped line store: valid/tag/data arrays with combinational lookup
// and a whole-line refill on the rising edge.
module cache_memory
  import cached_memory_pkg::*;
#(
  parameter int DATA_WIDTH = WORD_LENGTH
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [ADDR_WIDTH-1:0]                  address,
  input  logic                                   write,
  input  logic [BLOCK_WORDS-1:0][DATA_WIDTH-1:0] block_in,
  output logic                                   hit,
  output logic [DATA_WIDTH-1:0]                  word
);

  logic [LINE_COUNT-1:0]                  valid_reg;
  logic [TAG_WIDTH-1:0]                   tag_mem  [LINE_COUNT];
  logic [BLOCK_WORDS-1:0][DATA_WIDTH-1:0] data_mem [LINE_COUNT];
  addr_fields_t                           fields;

  assign fields = split_address(address);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_reg <= '0;
    end else if (write) begin
      valid_reg[fields.index] <= 1'b1;
    end
  end

  // Tags and data carry no reset; validity alone decides whether they mean anything.
  always_ff @(posedge clk) begin
    if (rst_n && write) begin
      tag_mem[fields.index]  <= fields.tag;
      data_mem[fields.index] <= block_in;
    end
  end

  assign hit  = valid_reg[fields.index] && (tag_mem[fields.index] == fields.tag);
  assign word = data_mem[fields.index][fields.offset];

endmodule

// File: rtl/main_memory.sv
// Read-only backing store: the word at address A holds A itself, zero-extended.
// Returns the whole 4-word block combinationally.
module main_memory
  import cached_memory_pkg::*;
#(
  parameter int DATA_WIDTH = WORD_LENGTH
) (
  input  logic [ADDR_WIDTH-OFFSET_WIDTH-1:0]  block_address,
  output logic [BLOCK_WORDS-1:0][DATA_WIDTH-1:0] block
);

  for (genvar gi = 0; gi < BLOCK_WORDS; gi++) begin : g_word
    assign block[gi] = DATA_WIDTH'({block_address, OFFSET_WIDTH'(gi)});
  end

endmodule

// File: rtl/memory_controller.sv
// Chooses the cached word on a hit, the backing-store word on a miss,
// and requests a refill of the addressed line whenever the lookup misses.
module memory_controller
  import cached_memory_pkg::*;
#(
  parameter int DATA_WIDTH = WORD_LENGTH
) (
  input  logic                                   hit,
  input  logic [OFFSET_WIDTH-1:0]                offset,
  input  logic [DATA_WIDTH-1:0]                  cache_word,
  input  logic [BLOCK_WORDS-1:0][DATA_WIDTH-1:0] mem_block,
  output logic [DATA_WIDTH-1:0]                  mem_out,
  output logic                                   cache_write
);

  always_comb begin
    cache_write = 1'b0;
    mem_out     = mem_block[offset];
    if (hit) begin
      mem_out = cache_word;
    end else begin
      cache_write = 1'b1;
    end
  end

endmodule

// File: rtl/cached_memory.sv
// Read-only memory behind a direct-mapped cache, with saturating access/hit counters.
module cached_memory
  import cached_memory_pkg::ADDR_WIDTH, cached_memory_pkg::OFFSET_WIDTH, cached_memory_pkg::BLOCK_WORDS;
#(
  parameter int WORD_LENGTH = cached_memory_pkg::WORD_LENGTH,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ADDR_WIDTH-1:0]  address,
  output logic                   hit,
  output logic [WORD_LENGTH-1:0] mem_out,
  output logic [CNT_WIDTH-1:0]   access_count,
  output logic [CNT_WIDTH-1:0]   hit_count
);

  logic                                    cache_write;
  logic [WORD_LENGTH-1:0]                  cache_word;
  logic [BLOCK_WORDS-1:0][WORD_LENGTH-1:0] mem_block;
  logic [CNT_WIDTH-1:0]                    access_count_reg;
  logic [CNT_WIDTH-1:0]                    hit_count_reg;

  main_memory #(.DATA_WIDTH(WORD_LENGTH)) u_main_memory (
    .block_address (address[ADDR_WIDTH-1:OFFSET_WIDTH]),
    .block         (mem_block)
  );

  cache_memory #(.DATA_WIDTH(WORD_LENGTH)) u_cache_memory (
    .clk      (clk),
    .rst_n    (rst_n),
    .address  (address),
    .write    (cache_write),
    .block_in (mem_block),
    .hit      (hit),
    .word     (cache_word)
  );

  memory_controller #(.DATA_WIDTH(WORD_LENGTH)) u_memory_controller (
    .hit         (hit),
    .offset      (address[OFFSET_WIDTH-1:0]),
    .cache_word  (cache_word),
    .mem_block   (mem_block),
    .mem_out     (mem_out),
    .cache_write (cache_write)
  );

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      access_count_reg <= '0;
      hit_count_reg    <= '0;
    end else begin
      if (access_count_reg != '1) access_count_reg <= access_count_reg + 1'b1;
      if (hit && (hit_count_reg != '1)) hit_count_reg <= hit_count_reg + 1'b1;
    end
  end

  assign access_count = access_count_reg;
  assign hit_count    = hit_count_reg;

endmodule

// File: tb/tb_cached_memory.sv
// Bench for cached_memory: table of lookups, an address sweep, reset and
// counter-saturation sequences, all checked against a scoreboard queue.
module tb_cached_memory;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [14:0] address = '0;
  logic        hit;
  logic [31:0] mem_out;
  logic [15:0] access_count, hit_count;
  logic        hit_s;
  logic [31:0] mem_out_s;
  logic [7:0]  access_count_s, hit_count_s;

  always #5 clk = ~clk;

  cached_memory dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .address      (address),
    .hit          (hit),
    .mem_out      (mem_out),
    .access_count (access_count),
    .hit_count    (hit_count)
  );

  // Narrow-counter copy so saturation is reachable in a few hundred cycles.
  cached_memory #(.CNT_WIDTH(8)) dut_small (
    .clk          (clk),
    .rst_n        (rst_n),
    .address      (address),
    .hit          (hit_s),
    .mem_out      (mem_out_s),
    .access_count (access_count_s),
    .hit_count    (hit_count_s)
  );

  typedef struct {
    logic [14:0] addr;
    logic        exp_hit;
    logic [31:0] exp_data;
  } vec_t;

  typedef struct {
    logic [14:0] addr;
    logic        hit;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
    end
  endtask

  // New inputs go in just after the rising edge; outputs are sampled on the falling edge.
  task automatic step(input logic [14:0] a, input logic r);
    @(posedge clk);
    #1;
    address = a;
    rst_n   = r;
    @(negedge clk);
  endtask

  task automatic compare_front();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
      return;
    end
    e = sb.pop_front();
    $display("access addr=0x%04h hit=%0d mem_out=0x%08h (want hit=%0d mem_out=0x%08h)",
             e.addr, hit, mem_out, e.hit, e.data);
    check($sformatf("hit@%04h", e.addr), {31'b0, hit}, {31'b0, e.hit});
    check($sformatf("mem_out@%04h", e.addr), mem_out, e.data);
  endtask

  task automatic access(input logic [14:0] a, input logic exp_hit, input logic [31:0] exp_data);
    step(a, 1'b1);
    sb.push_back('{a, exp_hit, exp_data});
    compare_front();
  endtask

  initial begin
    tbl = '{
      '{15'h0005, 1'b0, 32'h0000_0005},
      '{15'h0005, 1'b1, 32'h0000_0005},
      '{15'h0004, 1'b1, 32'h0000_0004},
      '{15'h0006, 1'b1, 32'h0000_0006},
      '{15'h0007, 1'b1, 32'h0000_0007},
      '{15'h0010, 1'b0, 32'h0000_0010},
      '{15'h0410, 1'b0, 32'h0000_0410},
      '{15'h0010, 1'b0, 32'h0000_0010},
      '{15'h0010, 1'b1, 32'h0000_0010},
      '{15'h0413, 1'b0, 32'h0000_0413},
      '{15'h7FFF, 1'b0, 32'h0000_7FFF},
      '{15'h7FFC, 1'b1, 32'h0000_7FFC}
    };

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_access_count", 32'(access_count), 32'd0);
    check("reset_hit_count", 32'(hit_count), 32'd0);
    check("reset_hit", {31'b0, hit}, 32'd0);

    // Lookup table: first access after reset, conflicts, offsets, top of memory
    for (int i = 0; i < 12; i++) begin
      access(tbl[i].addr, tbl[i].exp_hit, tbl[i].exp_data);
    end
    step(15'h0000, 1'b0);
    check("table_access_count", 32'(access_count), 32'd12);
    check("table_hit_count", 32'(hit_count), 32'd6);

    // Sequential sweep from a fresh reset: one miss per block
    for (int a = 0; a < 1024; a++) begin
      access(15'(a), (a % 4) != 0, 32'(a));
    end
    step(15'h0000, 1'b0);
    check("sweep_access_count", 32'(access_count), 32'd1024);
    check("sweep_hit_count", 32'(hit_count), 32'd768);
    check("sat_access_count", 32'(access_count_s), 32'd255);
    check("sat_hit_count", 32'(hit_count_s), 32'd255);

    // Reset mid-sequence, including one cycle where a refill would otherwise happen
    access(15'h0020, 1'b0, 32'h20);
    access(15'h0021, 1'b1, 32'h21);
    step(15'h0040, 1'b0);
    sb.push_back('{15'h0040, 1'b0, 32'h40});
    compare_front();
    check("pre_reset_access_count", 32'(access_count), 32'd2);
    check("pre_reset_hit_count", 32'(hit_count), 32'd1);
    access(15'h0040, 1'b0, 32'h40);
    check("post_reset_access_count", 32'(access_count), 32'd0);
    check("post_reset_hit_count", 32'(hit_count), 32'd0);
    access(15'h0021, 1'b0, 32'h21);
    access(15'h0021, 1'b1, 32'h21);

    // Address moved mid-cycle: only the address present at the edge is refilled
    access(15'h0080, 1'b0, 32'h80);
    #2;
    address = 15'h0090;
    #1;
    sb.push_back('{15'h0090, 1'b0, 32'h90});
    compare_front();
    access(15'h0091, 1'b1, 32'h91);
    access(15'h0081, 1'b0, 32'h81);

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
